file_ram: RTL and testbench
===========================

FILE_RAM -- requirements
Module: file_ram

Interface
REQ-001 SHALL declare parameter DEPTH, default 128, number of 8-bit file registers.
REQ-002 SHALL declare parameter ADDR_W, default 7, file address width.
REQ-003 SHALL declare parameter DATA_W, default 8, file register width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 rd_phase  input  1  read strobe from the phase clock generator (Q2), one clk wide.
REQ-007 wr_phase  input  1  write strobe from the phase clock generator (Q4), one clk wide.
REQ-008 address  input  ADDR_W  file address from the instruction register.
REQ-009 writeEn  input  1  decoder write request, sampled only on wr_phase.
REQ-010 wdata  input  DATA_W  ALU result to store.
REQ-011 f  output  DATA_W  registered read data to the ALU operand mux.
REQ-012 f_valid  output  1  f holds data for the current instruction.
REQ-013 seq_err  output  1  sticky phase-sequence error flag.

Function
REQ-014 SHALL implement FSM states IDLE, READY, WRITE.
REQ-015 IDLE + rd_phase: SHALL latch effective address ea, load f <= mem[ea] at that edge, enter READY; f_valid=1 from next cycle.
REQ-016 READY + wr_phase + writeEn: SHALL capture ea/wdata, enter WRITE; f_valid=0 next cycle.
REQ-017 WRITE: SHALL commit mem[ea] <= wdata in exactly one cycle, return to IDLE.
REQ-018 READY + wr_phase + !writeEn: SHALL return to IDLE with no write; f_valid=0.
REQ-019 f SHALL keep its last value when f_valid=0.
REQ-020 rd_phase in WRITE: SHALL return the committing wdata when addresses match (bypass), else mem[ea]; enter READY.
REQ-021 rd_phase in READY: SHALL set seq_err and re-read using the new address.
REQ-022 wr_phase in IDLE or WRITE: SHALL set seq_err, no write.
REQ-023 rd_phase and wr_phase in the same cycle: wr_phase SHALL win, rd_phase ignored, seq_err set.
REQ-024 address >= DEPTH: reads SHALL return 0, writes discarded; no wrap-around.
REQ-025 seq_err SHALL clear only on reset.

Reset
REQ-026 reset low SHALL immediately force state=IDLE, f=0, f_valid=0, seq_err=0, all mem locations 0.
REQ-027 reset during WRITE SHALL abort the commit; location reads 0 afterwards.
REQ-028 first rd_phase after reset release SHALL be serviced normally.

Configuration
REQ-029 Macro FILE_RAM_INDIRECT_EN SHALL control indirect addressing.
REQ-030 Defined: address 0x00 (INDF) SHALL map ea=mem[0x04] (FSR) low ADDR_W bits; FSR=0 reads 0, writes discarded; FSR writes apply to the next read.
REQ-031 Undefined: address 0x00 SHALL be an ordinary location; ea=address always.

Structure
REQ-032 Package file_ram_pkg SHALL hold DEPTH/ADDR_W/DATA_W defaults, INDF_ADDR=0x00, FSR_ADDR=0x04, and the FSM state enum.
REQ-033 Sub-module file_ram_ea SHALL compute ea and out-of-range flag combinationally from address and FSR.

Verification
REQ-034 Write 0x5A to 0x20 (rd, wr+writeEn), then read 0x20 -> f=0x5A, f_valid=1 one cycle after rd_phase.
REQ-035 rd_phase on 0x20 in the WRITE cycle of a 0x77 write to 0x20 -> f=0x77 (bypass).
REQ-036 With FILE_RAM_INDIRECT_EN: write FSR=0x30, write 0x11 via address 0x00 -> mem[0x30]=0x11, read 0x00 returns 0x11; without macro mem[0x00]=0x11.
REQ-037 wr_phase in IDLE, then simultaneous rd/wr -> seq_err=1, memory unchanged, seq_err stays 1 until reset.
REQ-038 reset asserted during WRITE of 0xFF to 0x10 -> f=0, f_valid=0, later read of 0x10 returns 0x00.
REQ-039 Read address 0x7F with DEPTH=64 -> f=0x00; write there leaves all locations unchanged.

Source files
------------

// File: rtl/file_ram_pkg.sv
// file_ram_pkg: shared defaults, special file addresses and FSM state
// encoding for the file register RAM.
package file_ram_pkg;

    localparam int unsigned DEPTH_DEF  = 32'd128;
    localparam int unsigned ADDR_W_DEF = 32'd7;
    localparam int unsigned DATA_W_DEF = 32'd8;

    // INDF: indirect data access, FSR: pointer used by INDF
    localparam logic [7:0] INDF_ADDR = 8'h00;
    localparam logic [7:0] FSR_ADDR  = 8'h04;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        WRITE = 2'd2
    } state_e;

    // True when a zero-extended file address maps to a physical register.
    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/file_ram_ea.sv
// file_ram_ea: effective-address generation for the file register RAM.
// With FILE_RAM_INDIRECT_EN defined, address INDF resolves through the FSR
// contents; an FSR pointing at location 0 behaves as a void access.
// Without the macro the effective address is the instruction address.
// ea_oob flags accesses that must read as zero and must never be written.
module file_ram_ea
    import file_ram_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] fsr,
    output logic [ADDR_W-1:0] ea,
    output logic              ea_oob
);

`ifdef FILE_RAM_INDIRECT_EN
    logic indf_s;

    // Resolve INDF through the FSR pointer, flag out-of-range and null pointers.
    always_comb begin
        indf_s = (address == ADDR_W'(INDF_ADDR));
        if (indf_s) begin
            ea = fsr[ADDR_W-1:0];
        end else begin
            ea = address;
        end
        ea_oob = !addr_in_range(32'(ea), DEPTH) ||
                 (indf_s && (ea == {ADDR_W{1'b0}}));
    end
`else
    logic unused_fsr_s;

    // Direct addressing only: the FSR value plays no part.
    always_comb begin
        ea           = address;
        ea_oob       = !addr_in_range(32'(address), DEPTH);
        unused_fsr_s = ^fsr;
    end
`endif

endmodule

// File: rtl/file_ram.sv
// file_ram: phase-strobed file register RAM. A Q2 read strobe loads f from
// the addressed register, a Q4 write strobe (with writeEn) schedules a
// one-cycle commit of wdata. Sequence violations raise a sticky seq_err.
// Optional feature: define FILE_RAM_INDIRECT_EN for INDF/FSR indirection.
module file_ram
    import file_ram_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_phase,
    input  logic              wr_phase,
    input  logic [ADDR_W-1:0] address,
    input  logic              writeEn,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] f,
    output logic              f_valid,
    output logic              seq_err
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    state_e            state_r;
    state_e            state_s;

    logic [ADDR_W-1:0] wea_r;
    logic [DATA_W-1:0] wdata_r;
    logic              wvoid_r;
    logic [DATA_W-1:0] f_r;
    logic              f_valid_r;
    logic              seq_err_r;

    logic [ADDR_W-1:0] ea_s;
    logic              ea_oob_s;
    logic [DATA_W-1:0] fsr_s;
    logic              commit_s;
    logic              bypass_s;
    logic [DATA_W-1:0] read_val_s;
    logic              load_f_s;
    logic              capture_s;
    logic              err_set_s;

    // Commit, read bypass and FSR forwarding around the pending write.
    always_comb begin
        commit_s = (state_r == WRITE) && !wvoid_r;
        if (commit_s && (wea_r == ADDR_W'(FSR_ADDR))) begin
            fsr_s = wdata_r;
        end else begin
            fsr_s = mem_r[ADDR_W'(FSR_ADDR)];
        end
    end

    file_ram_ea #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ea (
        .address (address),
        .fsr     (fsr_s),
        .ea      (ea_s),
        .ea_oob  (ea_oob_s)
    );

    // Read data: zero for void accesses, the committing data on an address hit.
    always_comb begin
        bypass_s = commit_s && !ea_oob_s && (wea_r == ea_s);
        if (ea_oob_s) begin
            read_val_s = {DATA_W{1'b0}};
        end else if (bypass_s) begin
            read_val_s = wdata_r;
        end else begin
            read_val_s = mem_r[ea_s];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; wr_phase always takes priority over rd_phase.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (wr_phase) begin
                    state_s = IDLE;
                end else if (rd_phase) begin
                    state_s = READY;
                end else begin
                    state_s = IDLE;
                end
            end
            READY: begin
                if (wr_phase) begin
                    state_s = writeEn ? WRITE : IDLE;
                end else begin
                    state_s = READY;
                end
            end
            WRITE: begin
                if (wr_phase) begin
                    state_s = IDLE;
                end else if (rd_phase) begin
                    state_s = READY;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM action decode: f load, write capture and sequence-error detection.
    // A stray wr_phase during WRITE flags an error but the already captured
    // commit still completes this cycle.
    always_comb begin
        load_f_s  = 1'b0;
        capture_s = 1'b0;
        err_set_s = 1'b0;
        case (state_r)
            IDLE, WRITE: begin
                if (wr_phase) begin
                    err_set_s = 1'b1;
                end else if (rd_phase) begin
                    load_f_s = 1'b1;
                end else begin
                    load_f_s = 1'b0;
                end
            end
            READY: begin
                if (wr_phase) begin
                    capture_s = writeEn;
                    err_set_s = rd_phase;
                end else if (rd_phase) begin
                    err_set_s = 1'b1;
                    load_f_s  = 1'b1;
                end else begin
                    load_f_s = 1'b0;
                end
            end
            default: begin
                err_set_s = 1'b1;
            end
        endcase
    end

    // Output and write-capture registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_r       <= {DATA_W{1'b0}};
            f_valid_r <= 1'b0;
            seq_err_r <= 1'b0;
            wea_r     <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            wvoid_r   <= 1'b1;
        end else begin
            f_valid_r <= (state_s == READY);
            seq_err_r <= seq_err_r | err_set_s;
            if (load_f_s) begin
                f_r <= read_val_s;
            end
            if (capture_s) begin
                wea_r   <= ea_s;
                wdata_r <= wdata;
                wvoid_r <= ea_oob_s;
            end
        end
    end

    // Register file storage: cleared by reset, written only in the WRITE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (commit_s) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (wea_r == ADDR_W'(i)) begin
                    mem_r[i] <= wdata_r;
                end
            end
        end
    end

    assign f       = f_r;
    assign f_valid = f_valid_r;
    assign seq_err = seq_err_r;

endmodule

// File: tb/tb_file_ram.sv
// tb_file_ram: self-checking bench for file_ram, instantiated with DEPTH=64
// so that addresses 0x40..0x7F are out of range.
module tb_file_ram;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_phase;
    logic              wr_phase;
    logic [ADDR_W-1:0] address;
    logic              writeEn;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] f;
    logic              f_valid;
    logic              seq_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    file_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_phase (rd_phase),
        .wr_phase (wr_phase),
        .address  (address),
        .writeEn  (writeEn),
        .wdata    (wdata),
        .f        (f),
        .f_valid  (f_valid),
        .seq_err  (seq_err)
    );

    typedef struct {
        logic       rd;
        logic       wr;
        logic       we;
        logic [6:0] a;
        logic [7:0] d;
        logic [7:0] ef;
        logic       ev;
        logic       ee;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rd, input logic wr, input logic we,
                                input logic [6:0] a, input logic [7:0] d,
                                input logic [7:0] ef, input logic ev, input logic ee);
        vec_t v;
        v.rd = rd; v.wr = wr; v.we = we; v.a = a; v.d = d;
        v.ef = ef; v.ev = ev; v.ee = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] ef, input logic ev, input logic ee);
        check({name, ".f"}, 32'(f), 32'(ef));
        check({name, ".f_valid"}, 32'(f_valid), 32'(ev));
        check({name, ".seq_err"}, 32'(seq_err), 32'(ee));
    endtask

    // One clock cycle with the given strobes; outputs settle 1 time unit after the edge.
    task automatic cyc(input logic rd, input logic wr, input logic we,
                       input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        rd_phase = rd;
        wr_phase = wr;
        writeEn  = we;
        address  = a;
        wdata    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rd_phase = 1'b0; wr_phase = 1'b0; writeEn = 1'b0;
        address  = 7'h00; wdata = 8'h00;
        reset    = 1'b0;
        #1;
        check_out(name, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [7:0] mdl [128];

    initial begin
        logic [6:0] a;
        logic [6:0] prev_a;
        logic [7:0] d;
        logic [7:0] exp_f;
        logic       we;
        int         amin;

        reset = 1'b0; rd_phase = 1'b0; wr_phase = 1'b0; writeEn = 1'b0;
        address = 7'h00; wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Main table: write/read, bypass, out-of-range, sequence errors.
        tbl.push_back(mk(1, 0, 0, 7'h20, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 1, 7'h20, 8'h5A, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 7'h20, 8'h00, 8'h5A, 1, 0));
        tbl.push_back(mk(0, 1, 0, 7'h20, 8'h00, 8'h5A, 0, 0));
        tbl.push_back(mk(1, 0, 0, 7'h20, 8'h00, 8'h5A, 1, 0));
        tbl.push_back(mk(0, 1, 1, 7'h20, 8'h77, 8'h5A, 0, 0));
        tbl.push_back(mk(1, 0, 0, 7'h20, 8'h00, 8'h77, 1, 0));
        tbl.push_back(mk(0, 1, 0, 7'h20, 8'h00, 8'h77, 0, 0));
        tbl.push_back(mk(1, 0, 0, 7'h21, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 1, 7'h21, 8'h33, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 7'h20, 8'h00, 8'h77, 1, 0));
        tbl.push_back(mk(0, 1, 0, 7'h20, 8'h00, 8'h77, 0, 0));
        tbl.push_back(mk(1, 0, 0, 7'h21, 8'h00, 8'h33, 1, 0));
        tbl.push_back(mk(0, 1, 0, 7'h21, 8'h00, 8'h33, 0, 0));
        tbl.push_back(mk(1, 0, 0, 7'h7F, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 1, 7'h7F, 8'hAB, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 7'h3F, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 7'h3F, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 7'h20, 8'h00, 8'h77, 1, 0));
        tbl.push_back(mk(0, 1, 0, 7'h20, 8'h00, 8'h77, 0, 0));
        tbl.push_back(mk(0, 1, 1, 7'h20, 8'h99, 8'h77, 0, 1));
        tbl.push_back(mk(1, 1, 1, 7'h20, 8'h99, 8'h77, 0, 1));
        tbl.push_back(mk(1, 0, 0, 7'h20, 8'h00, 8'h77, 1, 1));
        tbl.push_back(mk(0, 1, 0, 7'h20, 8'h00, 8'h77, 0, 1));
        tbl.push_back(mk(0, 0, 0, 7'h00, 8'h00, 8'h77, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rd, tbl[i].wr, tbl[i].we, tbl[i].a, tbl[i].d);
            check_out($sformatf("tbl[%0d]", i), tbl[i].ef, tbl[i].ev, tbl[i].ee);
        end

        // Reset clears seq_err and memory; rd_phase in READY re-reads and flags.
        do_reset("rst_clear");
        cyc(1, 0, 0, 7'h20, 8'h00); check_out("after_rst_rd20", 8'h00, 1, 0);
        cyc(0, 1, 1, 7'h22, 8'h5C); check_out("wr22", 8'h00, 0, 0);
        idle();
        cyc(1, 0, 0, 7'h20, 8'h00); check_out("rd20", 8'h00, 1, 0);
        cyc(1, 0, 0, 7'h22, 8'h00); check_out("reread22", 8'h5C, 1, 1);
        cyc(0, 1, 0, 7'h22, 8'h00); check_out("reread_end", 8'h5C, 0, 1);
        do_reset("rst_err");
        cyc(1, 1, 0, 7'h22, 8'h00); check_out("rdwr_idle", 8'h00, 0, 1);
        cyc(1, 0, 0, 7'h22, 8'h00); check_out("rdwr_nowrite", 8'h00, 1, 1);
        idle();
        do_reset("rst_err2");

        // Reset asserted during the WRITE cycle aborts the commit.
        cyc(1, 0, 0, 7'h11, 8'h00);
        cyc(0, 1, 1, 7'h11, 8'h42);
        idle();
        cyc(1, 0, 0, 7'h11, 8'h00); check_out("pre_abort", 8'h42, 1, 0);
        cyc(0, 1, 1, 7'h10, 8'hFF);
        rd_phase = 1'b0; wr_phase = 1'b0; writeEn = 1'b0;
        reset = 1'b0;
        #1;
        check_out("abort_immediate", 8'h00, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(1, 0, 0, 7'h10, 8'h00); check_out("abort_rd10", 8'h00, 1, 0);
        cyc(0, 1, 0, 7'h10, 8'h00);
        cyc(1, 0, 0, 7'h11, 8'h00); check_out("abort_rd11", 8'h00, 1, 0);
        cyc(0, 1, 0, 7'h11, 8'h00);

        // Indirect addressing scenario (expectations depend on the build).
        do_reset("rst_indf");
        cyc(1, 0, 0, 7'h04, 8'h00);
        cyc(0, 1, 1, 7'h04, 8'h30);
        idle();
        cyc(1, 0, 0, 7'h00, 8'h00);
        cyc(0, 1, 1, 7'h00, 8'h11);
        idle();
        cyc(1, 0, 0, 7'h00, 8'h00); check_out("indf_rd00", 8'h11, 1, 0);
        cyc(0, 1, 0, 7'h00, 8'h00);
        cyc(1, 0, 0, 7'h30, 8'h00);
`ifdef FILE_RAM_INDIRECT_EN
        check_out("indf_rd30", 8'h11, 1, 0);
`else
        check_out("indf_rd30", 8'h00, 1, 0);
`endif
        cyc(0, 1, 0, 7'h30, 8'h00);

        // Randomized legal instruction stream against an array model.
        do_reset("rst_rand");
        for (int i = 0; i < 128; i++) mdl[i] = 8'h00;
`ifdef FILE_RAM_INDIRECT_EN
        amin = 1;
`else
        amin = 0;
`endif
        prev_a = 7'h01;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3) == 0) a = prev_a;
            else a = 7'($urandom_range(127, amin));
            prev_a = a;
            exp_f = (int'(a) < int'(DEPTH)) ? mdl[a] : 8'h00;
            repeat ($urandom_range(2)) idle();
            cyc(1, 0, 0, a, 8'($urandom));
            check_out($sformatf("rnd%0d.rd", n), exp_f, 1, 0);
            repeat ($urandom_range(2)) begin
                idle();
                check(($sformatf("rnd%0d.hold", n)), 32'(f_valid), 32'd1);
            end
            we = 1'($urandom);
            d  = 8'($urandom);
            cyc(0, 1, we, a, d);
            check_out($sformatf("rnd%0d.wr", n), exp_f, 0, 0);
            if (we && (int'(a) < int'(DEPTH))) mdl[a] = d;
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
